squash_arbiter_l5: RTL

//  Subscriber end of the squash notification path. Collects single-cycle squash pulses from all

---
 rtl/squash_arbiter_l5_pkg.sv | 26 ++
 rtl/squash_arbiter_l5_oldest_sel.sv | 58 +++++
 rtl/squash_arbiter_l5.sv | 128 ++++++++++++
 3 files changed

// File: rtl/squash_arbiter_l5_pkg.sv
// rtl/squash_arbiter_l5_pkg.sv - shared types and sequence-age helper for the squash arbiter
//
// Purpose : state encoding of the squash arbiter FSM and the modular age function used by
//           every seq-ordered unit.
// Contents: c_seq_num_bits  sequence number width used by seq_num_t / seq_age
//           seq_num_t       sequence number type
//           squash_arb_state_t {SQ_IDLE, SQ_PEND}
//           seq_age(seq, base) = (seq - base) mod 2^c_seq_num_bits
package squash_arbiter_l5_pkg;

  localparam int unsigned c_seq_num_bits = 5;

  typedef logic [c_seq_num_bits-1:0] seq_num_t;

  typedef enum logic {
    SQ_IDLE = 1'b0,
    SQ_PEND = 1'b1
  } squash_arb_state_t;

  // Distance of seq from the oldest in-flight instruction; smaller means older.
  // Unsigned subtraction wraps naturally, which handles sequence number wrap-around.
  function automatic seq_num_t seq_age(input seq_num_t seq, input seq_num_t base);
    return seq - base;
  endfunction

endpackage

// File: rtl/squash_arbiter_l5_oldest_sel.sv
// rtl/squash_arbiter_l5_oldest_sel.sv - combinational pick of the oldest valid squash publisher
//
// Purpose : from all publishers pulsing this cycle, select the one with the smallest age
//           relative to commit_seq_num_i; ties go to the lowest publisher index.
// Ports   : pub_val_i        [p_num_pubs]         per-publisher squash pulse
//           pub_target_i     [p_num_pubs][32]     redirect PC per publisher
//           pub_seq_num_i    [p_num_pubs][SEQ]    seq num per publisher
//           commit_seq_num_i [SEQ]                age base
//           cand_val_o                            any publisher valid
//           cand_target_o    [32]                 target of the selected publisher
//           cand_seq_num_o   [SEQ]                seq num of the selected publisher
//           cand_age_o       [SEQ]                age of the selected publisher
module squash_oldest_sel
  import squash_arbiter_l5_pkg::*;
#(
  parameter int unsigned p_num_pubs     = 2,
  parameter int unsigned p_seq_num_bits = c_seq_num_bits
) (
  input  logic [p_num_pubs-1:0]                     pub_val_i,
  input  logic [p_num_pubs-1:0][31:0]               pub_target_i,
  input  logic [p_num_pubs-1:0][p_seq_num_bits-1:0] pub_seq_num_i,
  input  logic [p_seq_num_bits-1:0]                 commit_seq_num_i,
  output logic                                      cand_val_o,
  output logic [31:0]                               cand_target_o,
  output logic [p_seq_num_bits-1:0]                 cand_seq_num_o,
  output logic [p_seq_num_bits-1:0]                 cand_age_o
);

  logic                      best_val;
  logic [31:0]               best_target;
  logic [p_seq_num_bits-1:0] best_seq;
  logic [p_seq_num_bits-1:0] best_age;

  // Scan from index 0 upward; a later publisher replaces the current best only when
  // strictly older, so equal ages keep the lowest index.
  always_comb begin
    best_val    = 1'b0;
    best_target = '0;
    best_seq    = '0;
    best_age    = '0;
    for (int unsigned i = 0; i < p_num_pubs; i++) begin
      logic [p_seq_num_bits-1:0] age;
      age = seq_age(pub_seq_num_i[i], commit_seq_num_i);
      if (pub_val_i[i] && (!best_val || (age < best_age))) begin
        best_val    = 1'b1;
        best_target = pub_target_i[i];
        best_seq    = pub_seq_num_i[i];
        best_age    = age;
      end
    end
  end

  assign cand_val_o     = best_val;
  assign cand_target_o  = best_target;
  assign cand_seq_num_o = best_seq;
  assign cand_age_o     = best_age;

endmodule

// File: rtl/squash_arbiter_l5.sv
// rtl/squash_arbiter_l5.sv - squash subscriber: keeps the oldest squash as a redirect to fetch
//
// Purpose : collects squash pulses from all execute publishers, holds the oldest outstanding one
//           as a valid/ready redirect until fetch accepts, and emits a one-cycle registered kill
//           broadcast for every squash it accepts.
// Ports   : clk, rst (async, active-low)
//           pub_val/pub_target/pub_seq_num   squash publishers (no backpressure)
//           commit_seq_num                   seq num of oldest in-flight instr (age base)
//           redir_val/redir_rdy/redir_target/redir_seq_num   redirect to fetch
//           kill_val/kill_seq_num            one-cycle flush broadcast
//           stat_accepts/stat_drops          only when SQUASH_ARB_STATS_EN is defined
// Config  : SQUASH_ARB_STATS_EN adds accept/drop counters; default build omits them.
module squash_arbiter_l5
  import squash_arbiter_l5_pkg::*;
#(
  parameter int unsigned p_num_pubs     = 2,
  parameter int unsigned p_seq_num_bits = c_seq_num_bits
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [p_num_pubs-1:0]                     pub_val,
  input  logic [p_num_pubs-1:0][31:0]               pub_target,
  input  logic [p_num_pubs-1:0][p_seq_num_bits-1:0] pub_seq_num,
  input  logic [p_seq_num_bits-1:0]                 commit_seq_num,
  output logic                                      redir_val,
  input  logic                                      redir_rdy,
  output logic [31:0]                               redir_target,
  output logic [p_seq_num_bits-1:0]                 redir_seq_num,
  output logic                                      kill_val,
  output logic [p_seq_num_bits-1:0]                 kill_seq_num
`ifdef SQUASH_ARB_STATS_EN
  ,
  output logic [31:0]                               stat_accepts,
  output logic [31:0]                               stat_drops
`endif
);

  logic                      cand_val;
  logic [31:0]               cand_target;
  logic [p_seq_num_bits-1:0] cand_seq_num;
  logic [p_seq_num_bits-1:0] cand_age;

  squash_oldest_sel #(
    .p_num_pubs     (p_num_pubs),
    .p_seq_num_bits (p_seq_num_bits)
  ) u_oldest_sel (
    .pub_val_i        (pub_val),
    .pub_target_i     (pub_target),
    .pub_seq_num_i    (pub_seq_num),
    .commit_seq_num_i (commit_seq_num),
    .cand_val_o       (cand_val),
    .cand_target_o    (cand_target),
    .cand_seq_num_o   (cand_seq_num),
    .cand_age_o       (cand_age)
  );

  squash_arb_state_t         state_q;
  logic                      redir_val_q;
  logic [31:0]               redir_target_q;
  logic [p_seq_num_bits-1:0] redir_seq_q;
  logic                      kill_val_q;
  logic [p_seq_num_bits-1:0] kill_seq_q;

  logic [p_seq_num_bits-1:0] pend_age;
  logic                      accept;

  // Pending age is recomputed every cycle because commit_seq_num moves under it.
  assign pend_age = seq_age(redir_seq_q, commit_seq_num);
  assign accept   = cand_val && ((state_q == SQ_IDLE) || (cand_age < pend_age));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= SQ_IDLE;
      redir_val_q    <= 1'b0;
      redir_target_q <= '0;
      redir_seq_q    <= '0;
      kill_val_q     <= 1'b0;
      kill_seq_q     <= '0;
    end else begin
      kill_val_q <= accept;
      if (accept) begin
        // Covers IDLE entry, older overwrite and handshake-plus-accept alike.
        state_q        <= SQ_PEND;
        redir_val_q    <= 1'b1;
        redir_target_q <= cand_target;
        redir_seq_q    <= cand_seq_num;
        kill_seq_q     <= cand_seq_num;
      end else if ((state_q == SQ_PEND) && redir_rdy) begin
        state_q     <= SQ_IDLE;
        redir_val_q <= 1'b0;
      end
    end
  end

  assign redir_val     = redir_val_q;
  assign redir_target  = redir_target_q;
  assign redir_seq_num = redir_seq_q;
  assign kill_val      = kill_val_q;
  assign kill_seq_num  = kill_seq_q;

`ifdef SQUASH_ARB_STATS_EN
  logic [31:0] stat_accepts_q;
  logic [31:0] stat_drops_q;
  logic [31:0] num_valid;

  always_comb begin
    num_valid = '0;
    for (int unsigned i = 0; i < p_num_pubs; i++) begin
      num_valid = num_valid + 32'(pub_val[i]);
    end
  end

  // Every valid input that is not the accepted one counts as a drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_accepts_q <= '0;
      stat_drops_q   <= '0;
    end else begin
      stat_accepts_q <= stat_accepts_q + 32'(accept);
      stat_drops_q   <= stat_drops_q + (num_valid - 32'(accept));
    end
  end

  assign stat_accepts = stat_accepts_q;
  assign stat_drops   = stat_drops_q;
`endif

endmodule
